simon_playback_seq: RTL
=======================

Name: simon_playback_seq

Overview:
- Timed playback sequencer for the Simon datapath.
- Walks register-file addresses 0..last inclusive and fetches each stored pattern.
- Presents each pattern on the pattern LEDs for a fixed ON period, followed by a blank GAP period.
- The top-level Simon controller issues start when it enters Playback and waits for done before moving to Repeat; this replaces stepping playback by hand with uclk presses.

Parameters:
- ADDR_W, 6, register-file address width (64 entries)
- PAT_W, 4, pattern width (one bit per switch/LED)
- ON_CYCLES, 8, cycles each pattern is lit; must be >= 1
- GAP_CYCLES, 4, blank cycles after each pattern; 0 is legal and skips GAP
- CNT_W, 16, width of the interval counter; must hold max(ON_CYCLES, GAP_CYCLES)

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin playback; sampled only in IDLE
- abort  in  1  cancel playback; takes effect from any state
- last  in  ADDR_W  highest valid address; latched at start
- rd_addr  out  ADDR_W  register-file read address
- rd_data  in  PAT_W  register-file data, valid one cycle after rd_addr
- led_pat  out  PAT_W  pattern driven to the pattern LEDs
- led_en  out  1  high while a pattern is being shown
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when playback completes

Behaviour:
- Reset: state=IDLE, rd_addr=0, last_q=0, led_pat=0, led_en=0, busy=0, done=0, counter=0.
- States: IDLE, LOAD, SHOW, GAP, FIN. Encoding comes from the package.
- IDLE:
  - On start=1: latch last_q<=last, set rd_addr<=0, go to LOAD.
  - With start=0: stay in IDLE.
- LOAD:
  - Lasts exactly one cycle (read latency).
  - At the end of the cycle: led_pat<=rd_data, counter<=ON_CYCLES-1, go to SHOW.
- SHOW:
  - led_en=1 for exactly ON_CYCLES cycles.
  - When counter==0: if GAP_CYCLES>0, load counter<=GAP_CYCLES-1 and go to GAP; otherwise go straight to the end-of-entry decision.
- GAP:
  - led_en=0; led_pat holds its value.
  - When counter==0: take the end-of-entry decision.
- End-of-entry decision:
  - If rd_addr==last_q, go to FIN.
  - Otherwise rd_addr<=rd_addr+1 and go to LOAD.
- FIN:
  - done=1 for one cycle, busy still 1.
  - Next state is IDLE. rd_addr and led_pat hold their values.
- Timing:
  - Cycles per entry = 1+ON_CYCLES+GAP_CYCLES.
  - done is high in cycle (last+1)*(1+ON_CYCLES+GAP_CYCLES)+1 after the start-sampling edge.
- start while busy: ignored, no restart.
- abort:
  - Has priority over all transitions.
  - Next state is IDLE, led_en<=0; no done pulse.
  - abort and start together in IDLE: stay in IDLE.
- last=0: exactly one entry is shown.
- last=2^ADDR_W-1: the sequence ends at the top address; rd_addr never wraps.
- Changes on last while busy have no effect.
- Async reset mid-playback: immediate return to reset values; no done pulse.
- done and led_en are never high in the same cycle.

Optional Feature:
- Macro: SIMON_PB_SPEEDUP_EN.
- Defined:
  - SHOW length = max(1, ON_CYCLES >> last_q[ADDR_W-1:ADDR_W-2]), i.e. the display gets faster every quarter of the array.
  - GAP length is unchanged.
  - The counter load uses the shifted value.
- Undefined: SHOW length is always ON_CYCLES; no extra logic.

Decomposition:
- Package simon_pkg holds:
  - the state typedef/localparams (IDLE, LOAD, SHOW, GAP, FIN);
  - the LED mode constants shared with the Simon controller (INPUT 3'b001, PLAYBACK 3'b010, REPEAT 3'b100, DONE 3'b111);
  - the default ADDR_W/PAT_W.
- One sub-module, simon_interval_cnt:
  - CNT_W loadable down-counter with load/value inputs and a zero flag;
  - used for both SHOW and GAP.

Test Plan (ON_CYCLES=3, GAP_CYCLES=2, memory 0:4'b0001, 1:4'b0010, 2:4'b0100):
- Reset check: rst=1 -> all outputs 0. Release rst, hold start=0 for 10 cycles -> IDLE held, busy=0.
- Basic run: start with last=2.
  - rd_addr sequence 0,1,2.
  - led_en high 3 cycles, low 2 cycles, per entry.
  - led_pat 0001, 0010, 0100 in turn.
  - done pulses once, 19 cycles after start; busy falls the following cycle.
- Single entry: last=0 -> one SHOW of 0001, done 7 cycles after start.
- Busy/abort handling:
  - start re-pulsed mid-run -> ignored, sequence unchanged.
  - abort during SHOW of entry 1 -> IDLE next cycle, led_en=0, no done.
- Top address: last=63 -> rd_addr reaches 63, FIN, no wrap to 0. Separately, async rst asserted mid-GAP -> immediate reset values.
- SIMON_PB_SPEEDUP_EN with ON_CYCLES=8:
  - last=20 -> SHOW length 4;
  - last=63 -> SHOW length 1;
  - GAP length stays 2 in both cases.

Source files
------------

// File: rtl/simon_pkg.sv
// Shared Simon definitions: playback FSM state encoding, LED mode codes and
// default datapath widths.
package simon_pkg;

    localparam int ADDR_W_DEF = 6;
    localparam int PAT_W_DEF  = 4;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LOAD = 3'd1;
    localparam logic [2:0] ST_SHOW = 3'd2;
    localparam logic [2:0] ST_GAP  = 3'd3;
    localparam logic [2:0] ST_FIN  = 3'd4;

    // LED mode codes used by the top-level Simon controller
    localparam logic [2:0] LED_INPUT    = 3'b001;
    localparam logic [2:0] LED_PLAYBACK = 3'b010;
    localparam logic [2:0] LED_REPEAT   = 3'b100;
    localparam logic [2:0] LED_DONE     = 3'b111;

endpackage

// File: rtl/simon_playback_seq_if.sv
// Playback sequencer bundle: controller handshake, register-file read port
// and pattern LED drive.
interface simon_playback_seq_if #(
    parameter int ADDR_W = 6,
    parameter int PAT_W  = 4
);
    logic              start;
    logic              abort;
    logic [ADDR_W-1:0] last;
    logic [ADDR_W-1:0] rd_addr;
    logic [PAT_W-1:0]  rd_data;
    logic [PAT_W-1:0]  led_pat;
    logic              led_en;
    logic              busy;
    logic              done;

    modport master (
        output start, abort, last, rd_data,
        input  rd_addr, led_pat, led_en, busy, done
    );

    modport slave (
        input  start, abort, last, rd_data,
        output rd_addr, led_pat, led_en, busy, done
    );
endinterface

// File: rtl/simon_playback_seq_interval_cnt.sv
// Loadable down-counter timing the SHOW and GAP intervals; holds at zero.
module simon_interval_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] value,
    output logic             zero
);
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= value;
        else if (cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign zero = (cnt == '0);
endmodule

// File: rtl/simon_playback_seq.sv
// Timed playback of register-file entries 0..last onto the pattern LEDs.
// Optional SIMON_PB_SPEEDUP_EN shortens SHOW in each higher quarter of the array.
module simon_playback_seq
    import simon_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int PAT_W      = PAT_W_DEF,
    parameter int ON_CYCLES  = 8,
    parameter int GAP_CYCLES = 4,
    parameter int CNT_W      = 16
) (
    input  logic                clk,
    input  logic                rst,
    simon_playback_seq_if.slave pb
);
    localparam bit HAS_GAP = (GAP_CYCLES > 0);
    localparam logic [CNT_W-1:0] GAP_M1 = HAS_GAP ? CNT_W'(GAP_CYCLES - 1) : '0;

    logic [2:0]        state;
    logic [ADDR_W-1:0] last_q;
    logic [ADDR_W-1:0] rd_addr_q;
    logic [PAT_W-1:0]  led_pat_q;
    logic [CNT_W-1:0]  show_m1;
    logic              cnt_load;
    logic [CNT_W-1:0]  cnt_val;
    logic              cnt_zero;
    logic              last_entry;

`ifdef SIMON_PB_SPEEDUP_EN
    // ON period halves for every quarter of the array covered by last
    logic [CNT_W-1:0] on_shift;
    assign on_shift = CNT_W'(ON_CYCLES) >> last_q[ADDR_W-1 -: 2];
    assign show_m1  = (on_shift == '0) ? '0 : on_shift - 1'b1;
`else
    assign show_m1 = CNT_W'(ON_CYCLES - 1);
`endif

    assign last_entry = (rd_addr_q == last_q);

    always_comb begin
        cnt_load = 1'b0;
        cnt_val  = show_m1;
        if (state == ST_LOAD) begin
            cnt_load = 1'b1;
        end else if (state == ST_SHOW && cnt_zero && HAS_GAP) begin
            cnt_load = 1'b1;
            cnt_val  = GAP_M1;
        end
    end

    simon_interval_cnt #(.CNT_W(CNT_W)) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .load  (cnt_load),
        .value (cnt_val),
        .zero  (cnt_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            last_q    <= '0;
            rd_addr_q <= '0;
            led_pat_q <= '0;
        end else if (pb.abort) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (pb.start) begin
                    last_q    <= pb.last;
                    rd_addr_q <= '0;
                    state     <= ST_LOAD;
                end
                ST_LOAD: begin
                    led_pat_q <= pb.rd_data;
                    state     <= ST_SHOW;
                end
                ST_SHOW: if (cnt_zero) begin
                    if (HAS_GAP) begin
                        state <= ST_GAP;
                    end else if (last_entry) begin
                        state <= ST_FIN;
                    end else begin
                        rd_addr_q <= rd_addr_q + 1'b1;
                        state     <= ST_LOAD;
                    end
                end
                ST_GAP: if (cnt_zero) begin
                    if (last_entry) begin
                        state <= ST_FIN;
                    end else begin
                        rd_addr_q <= rd_addr_q + 1'b1;
                        state     <= ST_LOAD;
                    end
                end
                ST_FIN:  state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign pb.rd_addr = rd_addr_q;
    assign pb.led_pat = led_pat_q;
    assign pb.led_en  = (state == ST_SHOW);
    assign pb.busy    = (state != ST_IDLE);
    assign pb.done    = (state == ST_FIN);
endmodule
